cmd_mem_staged: RTL and testbench
=================================

// Module: cmd_mem_staged
// PURPOSE
//  Parametrised successor to the processor command memory. Host-side loader writes
//  narrow WRITE_WIDTH chunks, which are assembled in a staging register and committed
//  to a CMD_WIDTH-wide RAM as one atomic word. Core-side fetch is a synchronous,
//  read-first port with read enable/hold, 1- or 2-cycle latency and a valid flag.
//  Sits between the host config bus and each processor core's instruction fetch.
// PARAMETERS
//  CMD_WIDTH     128  command word width; must be an integer multiple of WRITE_WIDTH
//  WRITE_WIDTH   32   host write chunk width; NSUB=CMD_WIDTH/WRITE_WIDTH, power of 2, >=1
//  ADDR_WIDTH    8    command address width; depth = 2**ADDR_WIDTH
//  READ_LATENCY  1    1 = RAM output only; 2 = extra output register (timing)
//  SUB_W derived = $clog2(NSUB); 0 when NSUB==1
// PORTS
//  clk            in   1                      clock; all logic on posedge
//  reset          in   1                      synchronous, active-high reset
//  write_enable   in   1                      chunk write strobe
//  write_address  in   ADDR_WIDTH+SUB_W       {word addr, chunk index}; chunk index in LSBs
//  write_data     in   WRITE_WIDTH            chunk data; chunk i -> cmd bits [i*WW +: WW]
//  read_enable    in   1                      fetch strobe
//  read_address   in   ADDR_WIDTH             fetch word address
//  cmd_out        out  CMD_WIDTH              fetched command word
//  cmd_valid      out  1                      cmd_out holds data for a completed fetch
//  commit_pulse   out  1                      1-cycle pulse: a word was written to RAM
// BEHAVIOUR
//  Reset: staging<=0, cmd_out<=0, cmd_valid<=0, commit_pulse<=0, pipeline regs<=0.
//   RAM contents are NOT cleared by reset.
//  Write path:
//   - write_enable with chunk index i < NSUB-1: staging[i] <= write_data; no RAM write.
//   - write_enable with i == NSUB-1: RAM[word addr] <= {write_data, staging[NSUB-2:0]}
//     in the same cycle; staging<=0; commit_pulse=1 next cycle.
//   - Staging is not address-tagged: commit address is that of the last chunk only.
//     Chunks may arrive in any order; rewriting chunk i before commit overwrites it.
//   - NSUB==1: every write commits directly; staging unused.
//   - Reset mid-assembly discards staged chunks; a later commit writes zeros in them.
//   - reset has priority over write_enable in the same cycle (no RAM write).
//  Read path:
//   - read_enable at edge N: RAM read registered; READ_LATENCY=1 -> cmd_out, cmd_valid=1
//     after edge N+1; READ_LATENCY=2 -> after edge N+2 (fully pipelined, 1 fetch/cycle).
//   - read_enable low: cmd_valid deasserts on matching latency stage; cmd_out HOLDS
//     the last fetched word (no update).
//   - Read-first: fetch and commit to the same address in the same cycle returns the
//     pre-commit word; fetch on the following cycle returns the new word.
//   - reset mid-fetch: all in-flight fetches dropped; cmd_valid=0 until a new fetch.
//  Address widths are exact; no wrap or bounds logic needed (full 2**ADDR_WIDTH depth).
// TESTING  (CMD=128, WRITE=32, ADDR=8, LAT=1 unless stated)
//  1. Chunks 0..3 of word 5 = 11111111,22222222,33333333,44444444, then fetch 5 ->
//     cmd_out=44444444_33333333_22222222_11111111, cmd_valid=1 one cycle later;
//     commit_pulse exactly once, cycle after chunk 3.
//  2. Word 9=A, then same-cycle commit B to 9 + fetch 9 -> A; fetch 9 next cycle -> B.
//  3. Chunks 0,1 of word 2, reset, chunk 3=DDDDDDDD to word 2, fetch 2 ->
//     DDDDDDDD_00000000_00000000_00000000; word 2 unchanged before the commit.
//  4. Fetch 5 then read_enable low 4 cycles -> cmd_valid=0, cmd_out stays word 5.
//  5. LAT=2: back-to-back fetches 0,1,2 -> cmd_valid=1 cycles N+2..N+4, words in order.
//  6. NSUB=1 (WRITE=128): single write to 255 = all-ones, fetch 255 -> all-ones.

Source files
------------

// File: rtl/cmd_mem_staged.sv
// Command memory: host chunk writes are assembled in a staging register and committed
// to a wide RAM atomically; the core-side fetch port is read-first with 1 or 2 cycle latency.
module cmd_mem_staged #(
  parameter int CMD_WIDTH    = 128,
  parameter int WRITE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  localparam int NSUB  = CMD_WIDTH / WRITE_WIDTH,
  localparam int SUB_W = (NSUB > 1) ? $clog2(NSUB) : 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_enable,
  input  logic [ADDR_WIDTH+SUB_W-1:0] write_address,
  input  logic [WRITE_WIDTH-1:0]      write_data,
  input  logic                        read_enable,
  input  logic [ADDR_WIDTH-1:0]       read_address,
  output logic [CMD_WIDTH-1:0]        cmd_out,
  output logic                        cmd_valid,
  output logic                        commit_pulse
);

  logic [CMD_WIDTH-1:0]  mem [2**ADDR_WIDTH];
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [CMD_WIDTH-1:0]  commit_word;

  generate
    if (NSUB == 1) begin : g_direct
      assign commit_en   = write_enable && !reset;
      assign commit_addr = write_address;
      assign commit_word = write_data;
    end else begin : g_staged
      logic [SUB_W-1:0]                 chunk_idx;
      logic                             last_chunk;
      logic [CMD_WIDTH-WRITE_WIDTH-1:0] staging;

      assign chunk_idx   = write_address[SUB_W-1:0];
      assign commit_addr = write_address[SUB_W +: ADDR_WIDTH];
      assign last_chunk  = (chunk_idx == SUB_W'(NSUB - 1));
      assign commit_en   = write_enable && last_chunk && !reset;
      assign commit_word = {write_data, staging};

      // Staging is cleared on every commit so a word never inherits chunks of the previous one
      always_ff @(posedge clk) begin
        if (reset) begin
          staging <= '0;
        end else if (write_enable) begin
          if (last_chunk) begin
            staging <= '0;
          end else begin
            for (int i = 0; i < NSUB - 1; i++) begin
              if (chunk_idx == SUB_W'(i)) begin
                staging[i*WRITE_WIDTH +: WRITE_WIDTH] <= write_data;
              end
            end
          end
        end
      end
    end
  endgenerate

  // RAM contents survive reset; commit_en already excludes the reset cycle
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[commit_addr] <= commit_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit_en;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          cmd_out   <= '0;
          cmd_valid <= 1'b0;
        end else begin
          cmd_valid <= read_enable;
          if (read_enable) begin
            cmd_out <= mem[read_address];
          end
        end
      end
    end else begin : g_lat2
      logic [CMD_WIDTH-1:0] rd_data;
      logic                 rd_valid;

      // Output stage only loads on a valid fetch so cmd_out keeps the last fetched word
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data   <= '0;
          rd_valid  <= 1'b0;
          cmd_out   <= '0;
          cmd_valid <= 1'b0;
        end else begin
          rd_valid  <= read_enable;
          if (read_enable) begin
            rd_data <= mem[read_address];
          end
          cmd_valid <= rd_valid;
          if (rd_valid) begin
            cmd_out <= rd_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cmd_mem_staged.sv
// Directed bench for cmd_mem_staged: default build, a 2-cycle-latency build and a
// single-chunk (NSUB==1) build share one clock and reset.
module tb_cmd_mem_staged;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // default build: 128/32/8, latency 1
  logic         m_we, m_re, m_valid, m_pulse;
  logic [9:0]   m_wa;
  logic [31:0]  m_wd;
  logic [7:0]   m_ra;
  logic [127:0] m_out;

  // latency-2 build
  logic         l_we, l_re, l_valid, l_pulse;
  logic [9:0]   l_wa;
  logic [31:0]  l_wd;
  logic [7:0]   l_ra;
  logic [127:0] l_out;

  // single-chunk build
  logic         n_we, n_re, n_valid, n_pulse;
  logic [7:0]   n_wa;
  logic [127:0] n_wd;
  logic [7:0]   n_ra;
  logic [127:0] n_out;

  cmd_mem_staged dut (
    .clk(clk), .reset(reset),
    .write_enable(m_we), .write_address(m_wa), .write_data(m_wd),
    .read_enable(m_re), .read_address(m_ra),
    .cmd_out(m_out), .cmd_valid(m_valid), .commit_pulse(m_pulse)
  );

  cmd_mem_staged #(.READ_LATENCY(2)) dut_lat2 (
    .clk(clk), .reset(reset),
    .write_enable(l_we), .write_address(l_wa), .write_data(l_wd),
    .read_enable(l_re), .read_address(l_ra),
    .cmd_out(l_out), .cmd_valid(l_valid), .commit_pulse(l_pulse)
  );

  cmd_mem_staged #(.WRITE_WIDTH(128)) dut_n1 (
    .clk(clk), .reset(reset),
    .write_enable(n_we), .write_address(n_wa), .write_data(n_wd),
    .read_enable(n_re), .read_address(n_ra),
    .cmd_out(n_out), .cmd_valid(n_valid), .commit_pulse(n_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input logic [7:0] word, input logic [1:0] idx, input logic [31:0] data);
    m_we = 1'b1;
    m_wa = {word, idx};
    m_wd = data;
    tick();
    m_we = 1'b0;
  endtask

  function automatic logic [31:0] l_chunk(input int k, input int i);
    return 32'hC0DE_0000 | 32'(k << 8) | 32'(i);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    m_we = 0; m_re = 0; m_wa = '0; m_wd = '0; m_ra = '0;
    l_we = 0; l_re = 0; l_wa = '0; l_wd = '0; l_ra = '0;
    n_we = 0; n_re = 0; n_wa = '0; n_wd = '0; n_ra = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (m_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_cmd_out got %h want 0", m_out); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid got %b want 0", m_valid); end
    checks++;
    if (m_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_pulse got %b want 0", m_pulse); end
    checks++;
    if (l_valid !== 1'b0 || l_out !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_lat2 got valid %b out %h want 0/0", l_valid, l_out);
    end
  endtask

  task automatic test_assembly();
    logic [31:0] chunks [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin
      m_write(8'd5, 2'(i), chunks[i]);
      checks++;
      if (m_pulse !== (i == 3)) begin
        errors++; $display("[TB] FAIL assembly_pulse chunk %0d got %b want %b", i, m_pulse, (i == 3));
      end
    end
    m_re = 1'b1; m_ra = 8'd5;
    tick();
    m_re = 1'b0;
    checks++;
    if (m_pulse !== 1'b0) begin errors++; $display("[TB] FAIL assembly_pulse_once got %b want 0", m_pulse); end
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL assembly_valid got %b want 1", m_valid); end
    checks++;
    if (m_out !== 128'h44444444_33333333_22222222_11111111) begin
      errors++; $display("[TB] FAIL assembly_word got %h want 44444444333333332222222211111111", m_out);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid cycle %0d got %b want 0", c, m_valid); end
      checks++;
      if (m_out !== 128'h44444444_33333333_22222222_11111111) begin
        errors++; $display("[TB] FAIL hold_word cycle %0d got %h want word 5", c, m_out);
      end
    end
  endtask

  task automatic test_read_first();
    for (int i = 0; i < 4; i++) m_write(8'd9, 2'(i), 32'hA0000000 + 32'(i));
    for (int i = 0; i < 3; i++) m_write(8'd9, 2'(i), 32'hB0000000 + 32'(i));
    m_we = 1'b1; m_wa = {8'd9, 2'd3}; m_wd = 32'hB0000003;
    m_re = 1'b1; m_ra = 8'd9;
    tick();
    m_we = 1'b0;
    checks++;
    if (m_out !== 128'hA0000003_A0000002_A0000001_A0000000) begin
      errors++; $display("[TB] FAIL read_first_old got %h want A-word", m_out);
    end
    checks++;
    if (m_pulse !== 1'b1) begin errors++; $display("[TB] FAIL read_first_pulse got %b want 1", m_pulse); end
    tick();
    m_re = 1'b0;
    checks++;
    if (m_out !== 128'hB0000003_B0000002_B0000001_B0000000 || m_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL read_first_new got %h valid %b want B-word valid 1", m_out, m_valid);
    end
  endtask

  task automatic test_reset_mid_assembly();
    for (int i = 0; i < 4; i++) m_write(8'd2, 2'(i), 32'h20200000 + 32'(i));
    m_write(8'd2, 2'd0, 32'hCCCC0000);
    m_write(8'd2, 2'd1, 32'hCCCC0001);
    // reset coincides with a final chunk: the commit must be suppressed
    reset = 1'b1;
    m_we = 1'b1; m_wa = {8'd2, 2'd3}; m_wd = 32'hEEEEEEEE;
    tick();
    reset = 1'b0; m_we = 1'b0;
    checks++;
    if (m_pulse !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flags got pulse %b valid %b want 0/0", m_pulse, m_valid);
    end
    m_re = 1'b1; m_ra = 8'd2;
    tick();
    m_re = 1'b0;
    checks++;
    if (m_out !== 128'h20200003_20200002_20200001_20200000) begin
      errors++; $display("[TB] FAIL midreset_unchanged got %h want original word 2", m_out);
    end
    m_write(8'd2, 2'd3, 32'hDDDDDDDD);
    checks++;
    if (m_pulse !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pulse got %b want 1", m_pulse); end
    m_re = 1'b1; m_ra = 8'd2;
    tick();
    m_re = 1'b0;
    checks++;
    if (m_out !== 128'hDDDDDDDD_00000000_00000000_00000000) begin
      errors++; $display("[TB] FAIL midreset_commit got %h want DDDDDDDD000000000000000000000000", m_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w [3];
    for (int k = 0; k < 3; k++) begin
      w[k] = {l_chunk(k, 3), l_chunk(k, 2), l_chunk(k, 1), l_chunk(k, 0)};
      for (int i = 0; i < 4; i++) begin
        l_we = 1'b1; l_wa = {8'(k), 2'(i)}; l_wd = l_chunk(k, i);
        tick();
      end
    end
    l_we = 1'b0;
    l_re = 1'b1; l_ra = 8'd0;
    tick();
    checks++;
    if (l_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat2_early got valid %b want 0", l_valid); end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) l_ra = 8'(k + 1);
      else l_re = 1'b0;
      tick();
      checks++;
      if (l_valid !== 1'b1 || l_out !== w[k]) begin
        errors++; $display("[TB] FAIL lat2_word%0d got valid %b %h want 1 %h", k, l_valid, l_out, w[k]);
      end
    end
    tick();
    checks++;
    if (l_valid !== 1'b0 || l_out !== w[2]) begin
      errors++; $display("[TB] FAIL lat2_drain got valid %b %h want 0 %h", l_valid, l_out, w[2]);
    end
    // a fetch in flight when reset arrives must never surface
    l_re = 1'b1; l_ra = 8'd1;
    tick();
    l_re = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (l_valid !== 1'b0 || l_out !== 128'h0) begin
      errors++; $display("[TB] FAIL lat2_reset got valid %b %h want 0 0", l_valid, l_out);
    end
    tick();
    checks++;
    if (l_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat2_reset_drop got valid %b want 0", l_valid); end
  endtask

  task automatic test_single_chunk();
    n_we = 1'b1; n_wa = 8'd255; n_wd = '1;
    tick();
    n_wa = 8'd0; n_wd = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    tick();
    n_we = 1'b0;
    checks++;
    if (n_pulse !== 1'b1) begin errors++; $display("[TB] FAIL n1_pulse got %b want 1", n_pulse); end
    n_re = 1'b1; n_ra = 8'd255;
    tick();
    checks++;
    if (n_out !== {128{1'b1}} || n_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL n1_ones got %h valid %b want all ones 1", n_out, n_valid);
    end
    n_ra = 8'd0;
    tick();
    n_re = 1'b0;
    checks++;
    if (n_out !== 128'h01234567_89ABCDEF_FEDCBA98_76543210) begin
      errors++; $display("[TB] FAIL n1_word0 got %h want 0123456789ABCDEFFEDCBA9876543210", n_out);
    end
  endtask

  initial begin
    test_reset();
    test_assembly();
    test_hold();
    test_read_first();
    test_reset_mid_assembly();
    test_back_to_back();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
